// File: rtl/zeroriscy_axi_slave.sv
// AXI4 slave that turns write/read bursts into single-beat req/gnt/rvalid memory accesses.
// One AXI transaction at a time, one memory access outstanding.
module zeroriscy_axi_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic [7:0]        S_AXI_AWLEN,
    input  logic [2:0]        S_AXI_AWSIZE,
    input  logic [1:0]        S_AXI_AWBURST,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,

    input  logic [DATA_W-1:0] S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic              S_AXI_WLAST,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,

    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,

    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [7:0]        S_AXI_ARLEN,
    input  logic [2:0]        S_AXI_ARSIZE,
    input  logic [1:0]        S_AXI_ARBURST,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,

    output logic [DATA_W-1:0] S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RLAST,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,

    output logic              m_req,
    input  logic              m_gnt,
    output logic              m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid,
    input  logic              m_err
);

    typedef enum logic [2:0] {
        IDLE, W_DATA, W_REQ, W_CMPL, B_RESP, R_REQ, R_CMPL, R_DATA
    } state_t;

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [2:0]        SIZE_WORD = 3'b010;
    localparam logic [1:0]        RESP_OK   = 2'b00;
    localparam logic [1:0]        RESP_SLV  = 2'b10;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        remaining;
    logic [1:0]        burst;
    logic              size_ok;
    logic              err;
    logic              last_rd;

    logic              pick_rd;
    logic              pick_wr;
    logic              last_beat;
    logic              beat_err;
    logic [ADDR_W-1:0] next_addr;

    // On a simultaneous AW/AR request the channel not served last time wins.
    assign pick_rd = (state == IDLE) && S_AXI_ARVALID && (!S_AXI_AWVALID || !last_rd);
    assign pick_wr = (state == IDLE) && S_AXI_AWVALID && !pick_rd;
    assign S_AXI_ARREADY = pick_rd;
    assign S_AXI_AWREADY = pick_wr;

    assign last_beat = (remaining == 9'd1);
    assign beat_err  = size_ok && m_rvalid && m_err;
    // WRAP is walked like INCR; it is already flagged as an error at address time.
    assign next_addr = (burst == 2'b00) ? addr : addr + WORD_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            burst        <= '0;
            size_ok      <= 1'b0;
            err          <= 1'b0;
            last_rd      <= 1'b0;
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OK;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OK;
            S_AXI_RLAST  <= 1'b0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_be         <= '0;
            m_addr       <= '0;
            m_wdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_rd) begin
                        addr      <= S_AXI_ARADDR;
                        remaining <= {1'b0, S_AXI_ARLEN} + 9'd1;
                        burst     <= S_AXI_ARBURST;
                        size_ok   <= (S_AXI_ARSIZE == SIZE_WORD);
                        err       <= (S_AXI_ARSIZE != SIZE_WORD) || S_AXI_ARBURST[1];
                        last_rd   <= 1'b1;
                        state     <= R_REQ;
                        if (S_AXI_ARSIZE == SIZE_WORD) begin
                            m_req  <= 1'b1;
                            m_we   <= 1'b0;
                            m_be   <= '1;
                            m_addr <= {S_AXI_ARADDR[ADDR_W-1:2], 2'b00};
                        end
                    end else if (pick_wr) begin
                        addr         <= S_AXI_AWADDR;
                        remaining    <= {1'b0, S_AXI_AWLEN} + 9'd1;
                        burst        <= S_AXI_AWBURST;
                        size_ok      <= (S_AXI_AWSIZE == SIZE_WORD);
                        err          <= (S_AXI_AWSIZE != SIZE_WORD) || S_AXI_AWBURST[1];
                        last_rd      <= 1'b0;
                        S_AXI_WREADY <= 1'b1;
                        state        <= W_DATA;
                    end
                end

                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        S_AXI_WREADY <= 1'b0;
                        m_wdata      <= S_AXI_WDATA;
                        m_be         <= S_AXI_WSTRB;
                        if (S_AXI_WLAST != last_beat) begin
                            err <= 1'b1;
                        end
                        state <= W_REQ;
                        if (size_ok) begin
                            m_req  <= 1'b1;
                            m_we   <= 1'b1;
                            m_addr <= {addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end

                W_REQ: begin
                    if (!size_ok) begin
                        state <= W_CMPL;
                    end else if (m_gnt) begin
                        m_req <= 1'b0;
                        state <= W_CMPL;
                    end
                end

                // Beat count, not WLAST, decides when the write burst ends.
                W_CMPL: begin
                    if (!size_ok || m_rvalid) begin
                        err       <= err | beat_err;
                        addr      <= next_addr;
                        remaining <= remaining - 9'd1;
                        if (last_beat) begin
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (err || beat_err) ? RESP_SLV : RESP_OK;
                            state        <= B_RESP;
                        end else begin
                            S_AXI_WREADY <= 1'b1;
                            state        <= W_DATA;
                        end
                    end
                end

                B_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        S_AXI_BRESP  <= RESP_OK;
                        state        <= IDLE;
                    end
                end

                R_REQ: begin
                    if (!size_ok) begin
                        state <= R_CMPL;
                    end else if (m_gnt) begin
                        m_req <= 1'b0;
                        state <= R_CMPL;
                    end
                end

                // Memory errors only affect their own beat; burst-level errors affect every beat.
                R_CMPL: begin
                    if (!size_ok) begin
                        S_AXI_RDATA  <= '0;
                        S_AXI_RRESP  <= RESP_SLV;
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RLAST  <= last_beat;
                        state        <= R_DATA;
                    end else if (m_rvalid) begin
                        S_AXI_RDATA  <= m_rdata;
                        S_AXI_RRESP  <= (err || m_err) ? RESP_SLV : RESP_OK;
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RLAST  <= last_beat;
                        state        <= R_DATA;
                    end
                end

                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        S_AXI_RLAST  <= 1'b0;
                        addr         <= next_addr;
                        remaining    <= remaining - 9'd1;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            state <= R_REQ;
                            if (size_ok) begin
                                m_req  <= 1'b1;
                                m_addr <= {next_addr[ADDR_W-1:2], 2'b00};
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
